// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter that feeds bytes from NUM_REQ requesters
// into a single UART transmitter. Each grant latches the winner's byte, acks the
// requester for one cycle, strobes tx_start until the transmitter reports busy,
// then waits for the frame-complete pulse. A transmitter that never goes busy is
// abandoned after START_TIMEOUT cycles and a sticky error flag is raised.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [2:0]           grant_id,
    output logic                 arb_busy,
    output logic                 timeout_err
);

    localparam int unsigned    N_U       = NUM_REQ;
    localparam int             CNT_W     = $clog2(START_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(START_TIMEOUT);
    localparam logic [2:0]     PTR_RESET = 3'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DONE
    } state_t;

    state_t             state, state_n;
    logic [2:0]         rr_ptr, rr_ptr_n;
    logic [CNT_W-1:0]   cnt, cnt_n;

    logic [NUM_REQ-1:0] ack_n;
    logic               start_n;
    logic [7:0]         data_n;
    logic [2:0]         gid_n;
    logic               busy_n;
    logic               err_n;

    logic               pick_found;
    logic [2:0]         pick_id;
    logic [7:0]         pick_data;
    logic [NUM_REQ-1:0] pick_onehot;

    // Round-robin pick: the rotated search from rr_ptr+1 with wrap-around is done
    // as two ascending passes, indices above rr_ptr first, then the rest.
    always_comb begin
        pick_found  = 1'b0;
        pick_id     = '0;
        pick_data   = '0;
        pick_onehot = '0;
        for (int unsigned i = 0; i < N_U; i++) begin
            if (!pick_found && req[i] && (3'(i) > rr_ptr)) begin
                pick_found = 1'b1;
                pick_id    = 3'(i);
                pick_data  = req_data[8*i +: 8];
            end
        end
        for (int unsigned i = 0; i < N_U; i++) begin
            if (!pick_found && req[i] && (3'(i) <= rr_ptr)) begin
                pick_found = 1'b1;
                pick_id    = 3'(i);
                pick_data  = req_data[8*i +: 8];
            end
        end
        for (int unsigned j = 0; j < N_U; j++) begin
            pick_onehot[j] = pick_found && (3'(j) == pick_id);
        end
    end

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_n  = state;
        rr_ptr_n = rr_ptr;
        cnt_n    = cnt;
        ack_n    = '0;
        start_n  = tx_start;
        data_n   = tx_data;
        gid_n    = grant_id;
        err_n    = timeout_err;

        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_n  = ISSUE;
                    start_n  = 1'b1;
                    data_n   = pick_data;
                    ack_n    = pick_onehot;
                    gid_n    = pick_id;
                    rr_ptr_n = pick_id;
                    cnt_n    = '0;
                end
            end
            ISSUE: begin
                if (tx_busy) begin
                    state_n = WAIT_DONE;
                    start_n = 1'b0;
                end else begin
                    cnt_n = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                    if (cnt >= CNT_LAST) begin
                        state_n = IDLE;
                        start_n = 1'b0;
                        err_n   = 1'b1;
                    end
                end
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_n = IDLE;
                    start_n = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                start_n = 1'b0;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= PTR_RESET;
            cnt         <= '0;
            req_ack     <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            grant_id    <= '0;
            arb_busy    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_n;
            rr_ptr      <= rr_ptr_n;
            cnt         <= cnt_n;
            req_ack     <= ack_n;
            tx_start    <= start_n;
            tx_data     <= data_n;
            grant_id    <= gid_n;
            arb_busy    <= busy_n;
            timeout_err <= err_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the arbiter rules; a small transmitter model
// and random requesters generate the stimulus.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ack;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic           tx_busy = 1'b0;
    logic           tx_done = 1'b0;
    logic [2:0]     grant_id;
    logic           arb_busy;
    logic           timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ       (N),
        .START_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: 0 = idle, 1 = strobing start, 2 = frame in progress.
    int           m_mode;
    int           m_last;
    int           m_cnt;
    logic [N-1:0] e_ack;
    logic         e_start;
    logic [7:0]   e_data;
    logic [2:0]   e_gid;
    logic         e_busy;
    logic         e_err;

    task automatic model_reset();
        m_mode  = 0;
        m_last  = N - 1;
        m_cnt   = 0;
        e_ack   = '0;
        e_start = 1'b0;
        e_data  = '0;
        e_gid   = '0;
        e_busy  = 1'b0;
        e_err   = 1'b0;
    endtask

    // Applies the arbiter rules to the inputs that the next rising edge samples.
    task automatic model_advance();
        int w;
        w     = -1;
        e_ack = '0;
        if (m_mode == 0) begin
            if (req != '0) begin
                for (int k = 1; k <= N; k++)
                    if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
                e_ack[w] = 1'b1;
                e_start  = 1'b1;
                e_data   = req_data[8*w +: 8];
                e_gid    = 3'(w);
                m_last   = w;
                m_mode   = 1;
                m_cnt    = 0;
            end
        end else if (m_mode == 1) begin
            if (tx_busy) begin
                m_mode  = 2;
                e_start = 1'b0;
            end else begin
                m_cnt++;
                if (m_cnt >= TO) begin
                    m_mode  = 0;
                    e_start = 1'b0;
                    e_err   = 1'b1;
                end
            end
        end else begin
            if (tx_done) m_mode = 0;
        end
        e_busy = (m_mode != 0);
    endtask

    // Environment knobs and state.
    int  env_st = 0, dly = 0, flen = 0, cur_delay = 1, cur_flen = 1;
    bit  cur_never = 0, glitch_busy = 0;
    int  cfg_delay = 0, cfg_never = 0, cfg_flen = 0, ack_policy = 0;
    bit  req_auto = 0, glitch_en = 0, force_done = 0;
    int  ack_cnt = 0, start_cnt = 0;
    int  glog[$];

    function automatic int logged(input int k);
        return (glog.size() > k) ? glog[k] : 99;
    endfunction

    task automatic drive_env();
        tx_done = 1'b0;
        if (glitch_busy) begin
            tx_busy     = 1'b0;
            glitch_busy = 1'b0;
        end
        if (force_done) begin
            tx_done    = 1'b1;
            force_done = 1'b0;
        end else if (env_st == 0) begin
            if (tx_start) begin
                if (dly == 0) begin
                    cur_never = (cfg_never == 1) || (cfg_never == 2 && $urandom_range(0, 7) == 0);
                    cur_delay = (cfg_delay != 0) ? cfg_delay : int'($urandom_range(1, 4));
                end
                dly++;
                if (!cur_never && dly >= cur_delay) begin
                    tx_busy  = 1'b1;
                    env_st   = 1;
                    flen     = 0;
                    cur_flen = (cfg_flen != 0) ? cfg_flen : int'($urandom_range(1, 10));
                end
            end else begin
                dly = 0;
                if (glitch_en && !arb_busy && $urandom_range(0, 15) == 0) begin
                    if ($urandom_range(0, 1) == 1) tx_done = 1'b1;
                    else begin
                        tx_busy     = 1'b1;
                        glitch_busy = 1'b1;
                    end
                end
            end
        end else begin
            flen++;
            if (flen >= cur_flen) begin
                tx_busy = 1'b0;
                tx_done = 1'b1;
                env_st  = 0;
                dly     = 0;
            end
        end
    endtask

    task automatic drive_req();
        for (int i = 0; i < N; i++) begin
            if (req[i] && req_ack[i]) begin
                if (ack_policy == 0) req[i] = 1'b0;
                else if (ack_policy == 2) begin
                    if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
                    else req_data[8*i +: 8] = 8'($urandom);
                end
            end else if (req_auto) begin
                if (!req[i]) begin
                    if ($urandom_range(0, 5) == 0) begin
                        req[i]             = 1'b1;
                        req_data[8*i +: 8] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    req[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check("req_ack", req_ack, e_ack);
        check("tx_start", tx_start, e_start);
        check("tx_data", tx_data, e_data);
        check("grant_id", grant_id, e_gid);
        check("arb_busy", arb_busy, e_busy);
        check("timeout_err", timeout_err, e_err);
        if (req_ack != '0) begin
            ack_cnt++;
            for (int i = 0; i < N; i++) if (req_ack[i]) glog.push_back(i);
        end
        if (tx_start) start_cnt++;
        drive_env();
        drive_req();
        model_advance();
    endtask

    task automatic do_reset(input int hold);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_req_ack", req_ack, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_arb_busy", arb_busy, 0);
        check("rst_timeout_err", timeout_err, 0);
        model_reset();
        tx_busy     = 1'b0;
        tx_done     = 1'b0;
        env_st      = 0;
        dly         = 0;
        glitch_busy = 1'b0;
        repeat (hold) @(negedge clk);
        reset = 1'b0;
        model_advance();
        ack_cnt   = 0;
        start_cnt = 0;
        glog.delete();
    endtask

    initial begin
        model_reset();

        // Reset state and quiet idle.
        do_reset(2);
        repeat (3) step();

        // Single requester, transmitter busy after 2 cycles.
        req_data[7:0] = 8'h55;
        req           = 4'b0001;
        ack_policy    = 0;
        cfg_delay     = 2;
        cfg_flen      = 4;
        cfg_never     = 0;
        do_reset(2);
        repeat (20) step();
        check("single_grant", logged(0), 0);
        check("single_ack_count", ack_cnt, 1);
        check("single_start_cycles", start_cnt, 2);

        // All four requesters held: strict rotation.
        req_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req        = 4'b1111;
        ack_policy = 1;
        cfg_delay  = 0;
        cfg_flen   = 0;
        do_reset(2);
        repeat (150) step();
        check("rot_g0", logged(0), 0);
        check("rot_g1", logged(1), 1);
        check("rot_g2", logged(2), 2);
        check("rot_g3", logged(3), 3);
        check("rot_g4", logged(4), 0);

        // Sparse requesters after reset.
        req = 4'b1010;
        do_reset(2);
        repeat (100) step();
        check("sparse_g0", logged(0), 1);
        check("sparse_g1", logged(1), 3);
        check("sparse_g2", logged(2), 1);

        // Transmitter never goes busy: start timeout.
        req_data[23:16] = 8'($urandom);
        req             = 4'b0100;
        ack_policy      = 0;
        cfg_never       = 1;
        do_reset(2);
        repeat (90) step();
        check("to_start_cycles", start_cnt, TO);
        check("to_ack_count", ack_cnt, 1);
        check("to_err", timeout_err, 1);
        check("to_idle", arb_busy, 0);
        repeat (5) step();
        check("to_err_sticky", timeout_err, 1);

        // Reset in the middle of a frame, then fresh arbitration.
        cfg_never  = 0;
        cfg_delay  = 1;
        cfg_flen   = 40;
        req        = 4'b0010;
        ack_policy = 1;
        do_reset(2);
        repeat (8) step();
        check("mid_wait_state", {arb_busy, tx_start}, 2'b10);
        do_reset(2);
        repeat (6) step();
        check("post_rst_grant", logged(0), 1);
        check("post_rst_acks", ack_cnt, 1);

        // tx_done pulse while idle with nothing pending.
        req       = '0;
        cfg_delay = 0;
        cfg_flen  = 0;
        do_reset(2);
        force_done = 1'b1;
        repeat (6) step();
        check("idle_done_acks", ack_cnt, 0);
        check("idle_done_start", start_cnt, 0);
        check("idle_done_busy", arb_busy, 0);

        // Randomized traffic with glitches, occasional timeouts and a mid-run reset.
        req_auto  = 1;
        glitch_en = 1;
        cfg_never = 2;
        do_reset(2);
        for (int blk = 0; blk < 6; blk++) begin
            ack_policy = blk % 3;
            if (blk == 3) do_reset(1 + int'($urandom_range(0, 2)));
            repeat (500) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of byte requesters (2..8).
REQ-002 The block SHALL have parameter START_TIMEOUT, default 64, giving the clk cycles to wait for tx_busy after tx_start is raised.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port req, input, NUM_REQ, per-requester byte-pending level.
REQ-006 The block SHALL have port req_data, input, 8*NUM_REQ, packed bytes; requester i owns bits [8i+7:8i].
REQ-007 The block SHALL have port req_ack, output, NUM_REQ, one-hot one-cycle pulse marking that requester's byte as taken.
REQ-008 The block SHALL have port tx_start, output, 1, start strobe to the UART transmitter.
REQ-009 The block SHALL have port tx_data, output, 8, byte to the UART transmitter.
REQ-010 The block SHALL have port tx_busy, input, 1, transmitter busy level.
REQ-011 The block SHALL have port tx_done, input, 1, transmitter frame-complete pulse.
REQ-012 The block SHALL have port grant_id, output, 3, index of the current or last granted requester.
REQ-013 The block SHALL have port arb_busy, output, 1, high in every state except IDLE.
REQ-014 The block SHALL have port timeout_err, output, 1, sticky flag set on start timeout.

Function
REQ-015 The FSM SHALL have states IDLE, ISSUE, WAIT_DONE; all outputs SHALL be registered.
REQ-016 In IDLE with any req bit high, the block SHALL choose the first set bit searching from (rr_ptr+1) mod NUM_REQ upward with wrap-around.
REQ-017 On that edge, the block SHALL latch req_data of the winner into tx_data, set grant_id and rr_ptr to the winner, pulse req_ack[winner] for exactly one cycle, and enter ISSUE.
REQ-018 Latency: req sampled high in IDLE at edge n SHALL produce req_ack and tx_start high in the cycle after edge n.
REQ-019 In ISSUE, tx_start SHALL stay high until tx_busy is sampled high; then the FSM SHALL enter WAIT_DONE with tx_start low.
REQ-020 In ISSUE, if tx_busy stays low for START_TIMEOUT consecutive cycles, the block SHALL drop tx_start, set timeout_err, and return to IDLE; the byte is discarded and is not re-acked.
REQ-021 In WAIT_DONE, tx_done high SHALL return the FSM to IDLE on the next edge; arbitration for the next byte SHALL occur no earlier than the edge after IDLE is entered.
REQ-022 tx_done or tx_busy asserted while in IDLE SHALL be ignored.
REQ-023 tx_data SHALL remain stable from grant until return to IDLE; req_data changes after ack SHALL have no effect.
REQ-024 A requester whose req is still high after its ack SHALL NOT be served again while any other requester is pending (round-robin fairness); a lone requester SHALL be served back-to-back.
REQ-025 req deasserted by a requester before arbitration SHALL lose that request; nothing is queued.
REQ-026 At most one req_ack bit SHALL be high in any cycle, and never in ISSUE or WAIT_DONE.
REQ-027 The timeout counter SHALL be clog2(START_TIMEOUT+1) bits wide, cleared on entering ISSUE, and saturating.

Reset
REQ-028 Reset high SHALL at once force state IDLE, tx_start=0, tx_data=0, req_ack=0, grant_id=0, arb_busy=0, timeout_err=0, rr_ptr=NUM_REQ-1, and timeout counter 0.
REQ-029 Reset during ISSUE or WAIT_DONE SHALL abandon the in-flight byte with no ack or replay after release.
REQ-030 After reset release, the first grant SHALL go to the lowest-index pending requester.

Verification
REQ-031 req=0001, req_data[7:0]=0x55, transmitter model raises busy after 2 cycles -> req_ack=0001 one cycle, tx_data=0x55, tx_start high exactly until busy is seen, arb_busy until done+1.
REQ-032 req=1111 held, bytes 0xA0..0xA3 -> grant order 0,1,2,3,0 with one ack per frame.
REQ-033 After reset, req=1010 -> first grant_id=1, then 3, then 1.
REQ-034 req=0100, tx_busy held low -> tx_start high 64 cycles, then low, timeout_err=1 sticky, FSM IDLE, req_ack pulsed only once.
REQ-035 Reset asserted mid-WAIT_DONE with req=0010 pending -> all outputs reset immediately; after release grant_id=1 is re-arbitrated fresh.
REQ-036 tx_done pulse injected in IDLE with req=0 -> no state change, no ack, no tx_start.
